// File: rtl/fft32_pkg.sv
// rtl/fft32_pkg.sv - shared widths, types and helpers for the 32-point SDF FFT stage
//
// Purpose: common constants and types for sdf_bf_stage32 and twiddle_rom_32.
// Ports: none (package).
// Optional feature FFT_STAGE_SCALE_EN is applied in sdf_bf_stage32.
package fft32_pkg;

  localparam int DATA_W  = 22;
  localparam int TW_W    = 12;
  localparam int TW_FRAC = 10;
  localparam int FFT_N   = 32;
  localparam int HALF_N  = 16;
  localparam int CNT_W   = $clog2(FFT_N);

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [TW_W-1:0]   tw_t;

  // Phase is the counter MSB: A fills the delay line, B does the butterfly.
  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_e;

  // Sums come out in the low half of the frame, twiddled differences in the high half.
  function automatic logic [CNT_W-1:0] out_index(input logic [CNT_W-1:0] c);
    return c ^ CNT_W'(HALF_N);
  endfunction

endpackage

// File: rtl/twiddle_rom_32.sv
// rtl/twiddle_rom_32.sv - combinational cos/sin table for W32^k, k = 0..15
//
// Purpose: W32^k = cos(2*pi*k/32) - j*sin(2*pi*k/32) in Q2.10, rounded to nearest.
// Ports:
//   k_i   [3:0]  twiddle index
//   cos_o [11:0] cos term (signed Q2.10)
//   sin_o [11:0] sin term (signed Q2.10); caller negates it for the imaginary part
module twiddle_rom_32
  import fft32_pkg::*;
(
  input  logic [3:0] k_i,
  output tw_t        cos_o,
  output tw_t        sin_o
);

  always_comb begin
    cos_o = '0;
    sin_o = '0;
    case (k_i)
      4'd0:  begin cos_o = tw_t'(1024);  sin_o = tw_t'(0);    end
      4'd1:  begin cos_o = tw_t'(1004);  sin_o = tw_t'(200);  end
      4'd2:  begin cos_o = tw_t'(946);   sin_o = tw_t'(392);  end
      4'd3:  begin cos_o = tw_t'(851);   sin_o = tw_t'(569);  end
      4'd4:  begin cos_o = tw_t'(724);   sin_o = tw_t'(724);  end
      4'd5:  begin cos_o = tw_t'(569);   sin_o = tw_t'(851);  end
      4'd6:  begin cos_o = tw_t'(392);   sin_o = tw_t'(946);  end
      4'd7:  begin cos_o = tw_t'(200);   sin_o = tw_t'(1004); end
      4'd8:  begin cos_o = tw_t'(0);     sin_o = tw_t'(1024); end
      4'd9:  begin cos_o = tw_t'(-200);  sin_o = tw_t'(1004); end
      4'd10: begin cos_o = tw_t'(-392);  sin_o = tw_t'(946);  end
      4'd11: begin cos_o = tw_t'(-569);  sin_o = tw_t'(851);  end
      4'd12: begin cos_o = tw_t'(-724);  sin_o = tw_t'(724);  end
      4'd13: begin cos_o = tw_t'(-851);  sin_o = tw_t'(569);  end
      4'd14: begin cos_o = tw_t'(-946);  sin_o = tw_t'(392);  end
      4'd15: begin cos_o = tw_t'(-1004); sin_o = tw_t'(200);  end
      default: begin cos_o = '0; sin_o = '0; end
    endcase
  end

endmodule

// File: rtl/sdf_bf_stage32.sv
// rtl/sdf_bf_stage32.sv - radix-2 single-path delay-feedback stage, 32-point frame
//
// Purpose: phase counter, drain control, butterfly, twiddle multiplier and output
// register of one SDF stage; the 16-deep delay line lives outside this block.
// Optional feature: define FFT_STAGE_SCALE_EN to halve butterfly sums/differences.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid, x_re_in/x_im_in  input sample
//   fb_re_in/fb_im_in          oldest delay-line word
//   fb_en, fb_re_out/fb_im_out delay-line shift enable and write word (combinational)
//   out_valid, y_re_out/y_im_out, out_idx  registered stage output and frame position
module sdf_bf_stage32
  import fft32_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] x_re_in,
  input  logic signed [DATA_W-1:0] x_im_in,
  input  logic signed [DATA_W-1:0] fb_re_in,
  input  logic signed [DATA_W-1:0] fb_im_in,
  output logic                     fb_en,
  output logic signed [DATA_W-1:0] fb_re_out,
  output logic signed [DATA_W-1:0] fb_im_out,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] y_re_out,
  output logic signed [DATA_W-1:0] y_im_out,
  output logic [CNT_W-1:0]         out_idx
);

  localparam int PROD_W = DATA_W + TW_W;
  localparam int ACC_W  = PROD_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain_q, drain_d;
  logic             seen_b_q, seen_b_d;
  logic             out_valid_q, out_valid_d;
  data_t            y_re_q, y_re_d, y_im_q, y_im_d;
  logic [CNT_W-1:0] out_idx_q, out_idx_d;

  phase_e phase;
  logic   drain_start, drain_act, active;
  data_t  x_re, x_im;

  assign phase = phase_e'(cnt_q[CNT_W-1]);

  // A drain begins the moment a frame has wrapped back to 0 with no new input,
  // so the stored differences are flushed without a bubble cycle.
  assign drain_start = (cnt_q == '0) && seen_b_q && !in_valid && !drain_q;
  assign drain_act   = drain_q || drain_start;
  assign active      = in_valid || drain_act;

  assign x_re = in_valid ? x_re_in : '0;
  assign x_im = in_valid ? x_im_in : '0;

  // Butterfly in 23 bits, then narrowed to the data width.
  logic signed [DATA_W:0] sum_re, sum_im, diff_re, diff_im;
  data_t                  sum_re_n, sum_im_n, diff_re_n, diff_im_n;

  assign sum_re  = {fb_re_in[DATA_W-1], fb_re_in} + {x_re[DATA_W-1], x_re};
  assign sum_im  = {fb_im_in[DATA_W-1], fb_im_in} + {x_im[DATA_W-1], x_im};
  assign diff_re = {fb_re_in[DATA_W-1], fb_re_in} - {x_re[DATA_W-1], x_re};
  assign diff_im = {fb_im_in[DATA_W-1], fb_im_in} - {x_im[DATA_W-1], x_im};

`ifdef FFT_STAGE_SCALE_EN
  // Dropping the LSB of the signed 23-bit value is a floor shift by one.
  assign sum_re_n  = sum_re[DATA_W:1];
  assign sum_im_n  = sum_im[DATA_W:1];
  assign diff_re_n = diff_re[DATA_W:1];
  assign diff_im_n = diff_im[DATA_W:1];
`else
  assign sum_re_n  = sum_re[DATA_W-1:0];
  assign sum_im_n  = sum_im[DATA_W-1:0];
  assign diff_re_n = diff_re[DATA_W-1:0];
  assign diff_im_n = diff_im[DATA_W-1:0];
`endif

  // Twiddle multiply of the fed-back difference by W32^cnt[3:0].
  tw_t tw_cos, tw_sin, tw_im;

  twiddle_rom_32 u_twiddle_rom (
    .k_i   (cnt_q[3:0]),
    .cos_o (tw_cos),
    .sin_o (tw_sin)
  );

  assign tw_im = -tw_sin;

  logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [ACC_W-1:0]  acc_re, acc_im;
  data_t                    mul_re, mul_im;

  assign p_rr = PROD_W'(fb_re_in) * PROD_W'(tw_cos);
  assign p_ii = PROD_W'(fb_im_in) * PROD_W'(tw_im);
  assign p_ri = PROD_W'(fb_re_in) * PROD_W'(tw_im);
  assign p_ir = PROD_W'(fb_im_in) * PROD_W'(tw_cos);

  assign acc_re = {p_rr[PROD_W-1], p_rr} - {p_ii[PROD_W-1], p_ii};
  assign acc_im = {p_ri[PROD_W-1], p_ri} + {p_ir[PROD_W-1], p_ir};

  // Picking bits above TW_FRAC is the truncating arithmetic shift, low word kept.
  assign mul_re = acc_re[TW_FRAC +: DATA_W];
  assign mul_im = acc_im[TW_FRAC +: DATA_W];

  logic unused_bits;
  assign unused_bits = ^{acc_re[ACC_W-1:TW_FRAC+DATA_W], acc_re[TW_FRAC-1:0],
                         acc_im[ACC_W-1:TW_FRAC+DATA_W], acc_im[TW_FRAC-1:0],
                         sum_re, sum_im, diff_re, diff_im};

  // Delay-line write port.
  assign fb_en     = active && rst_n;
  assign fb_re_out = (phase == PH_B) ? diff_re_n : x_re;
  assign fb_im_out = (phase == PH_B) ? diff_im_n : x_im;

  always_comb begin
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    seen_b_d    = seen_b_q;
    out_valid_d = 1'b0;
    y_re_d      = y_re_q;
    y_im_d      = y_im_q;
    out_idx_d   = out_idx_q;
    if (active) begin
      cnt_d     = cnt_q + 1'b1;
      out_idx_d = out_index(cnt_q);
      if (phase == PH_B) begin
        out_valid_d = 1'b1;
        y_re_d      = sum_re_n;
        y_im_d      = sum_im_n;
        if (cnt_q == CNT_W'(FFT_N - 1)) begin
          seen_b_d = 1'b1;
        end
      end else begin
        // Phase A differences only exist once a full phase B has been written.
        out_valid_d = seen_b_q;
        y_re_d      = mul_re;
        y_im_d      = mul_im;
      end
      if (in_valid || cnt_q == CNT_W'(HALF_N - 1)) begin
        drain_d = 1'b0;
      end else begin
        drain_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      seen_b_q    <= 1'b0;
      out_valid_q <= 1'b0;
      y_re_q      <= '0;
      y_im_q      <= '0;
      out_idx_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      seen_b_q    <= seen_b_d;
      out_valid_q <= out_valid_d;
      y_re_q      <= y_re_d;
      y_im_q      <= y_im_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y_re_out  = y_re_q;
  assign y_im_out  = y_im_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_sdf_bf_stage32.sv
// tb/tb_sdf_bf_stage32.sv - scoreboard bench for sdf_bf_stage32 with a modelled delay line
module tb_sdf_bf_stage32;

  typedef struct {
    logic signed [21:0] re;
    logic signed [21:0] im;
    logic [4:0]         idx;
  } exp_t;

  localparam real PI = 3.141592653589793;

  logic               clk      = 1'b0;
  logic               rst_n    = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [21:0] x_re_in  = '0;
  logic signed [21:0] x_im_in  = '0;
  logic signed [21:0] fb_re_in, fb_im_in, fb_re_out, fb_im_out, y_re_out, y_im_out;
  logic               fb_en, out_valid;
  logic [4:0]         out_idx;

  logic signed [21:0] dl_re [16];
  logic signed [21:0] dl_im [16];

  exp_t exp_q[$];
  int   fr_re [32];
  int   fr_im [32];
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulses   = 0;

  sdf_bf_stage32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x_re_in   (x_re_in),
    .x_im_in   (x_im_in),
    .fb_re_in  (fb_re_in),
    .fb_im_in  (fb_im_in),
    .fb_en     (fb_en),
    .fb_re_out (fb_re_out),
    .fb_im_out (fb_im_out),
    .out_valid (out_valid),
    .y_re_out  (y_re_out),
    .y_im_out  (y_im_out),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  // External 16-deep delay line: oldest word at index 15.
  assign fb_re_in = dl_re[15];
  assign fb_im_in = dl_im[15];
  always @(posedge clk) begin
    if (fb_en) begin
      dl_re[0] <= fb_re_out;
      dl_im[0] <= fb_im_out;
      for (int i = 1; i < 16; i++) begin
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  function automatic logic signed [21:0] narrow(input longint v);
    longint t;
    t = v;
`ifdef FFT_STAGE_SCALE_EN
    t = v >>> 1;
`endif
    return t[21:0];
  endfunction

  function automatic longint tw_c(input int k);
    return longint'(1024.0 * $cos(2.0 * PI * real'(k) / 32.0));
  endfunction

  function automatic longint tw_s(input int k);
    return longint'(1024.0 * $sin(2.0 * PI * real'(k) / 32.0));
  endfunction

  // Reference DIF butterfly for the frame in fr_re/fr_im: sums then twiddled differences.
  task automatic push_frame();
    exp_t   e;
    longint dr, di, c, s, pr, pm;
    for (int n = 0; n < 16; n++) begin
      e.re  = narrow(longint'(fr_re[n]) + longint'(fr_re[n+16]));
      e.im  = narrow(longint'(fr_im[n]) + longint'(fr_im[n+16]));
      e.idx = 5'(n);
      exp_q.push_back(e);
    end
    for (int n = 0; n < 16; n++) begin
      dr    = narrow(longint'(fr_re[n]) - longint'(fr_re[n+16]));
      di    = narrow(longint'(fr_im[n]) - longint'(fr_im[n+16]));
      c     = tw_c(n);
      s     = tw_s(n);
      pr    = (dr * c + di * s) >>> 10;
      pm    = (di * c - dr * s) >>> 10;
      e.re  = pr[21:0];
      e.im  = pm[21:0];
      e.idx = 5'(n + 16);
      exp_q.push_back(e);
    end
  endtask

  // One clock: compare any valid output against the scoreboard, then cross the edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst_n && out_valid) begin
      pulses++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_extra: got idx=%0d y=%0d,%0d with nothing expected",
                 out_idx, y_re_out, y_im_out);
      end else begin
        e = exp_q.pop_front();
        if (y_re_out !== e.re || y_im_out !== e.im || out_idx !== e.idx) begin
          n_errors++;
          $display("FAIL sb_data: got idx=%0d y=%0d,%0d expected idx=%0d y=%0d,%0d",
                   out_idx, y_re_out, y_im_out, e.idx, e.re, e.im);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_valid = 1'b1;
      x_re_in  = 22'(fr_re[i]);
      x_im_in  = 22'(fr_im[i]);
      tick();
    end
    in_valid = 1'b0;
    x_re_in  = '0;
    x_im_in  = '0;
  endtask

  task automatic wait_empty(input int max);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max) begin
      tick();
      c++;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fill_const(input int re, input int im);
    for (int i = 0; i < 32; i++) begin
      fr_re[i] = re;
      fr_im[i] = im;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 32; i++) begin
      fr_re[i] = int'($urandom_range(0, 4194303)) - 2097152;
      fr_im[i] = int'($urandom_range(0, 4194303)) - 2097152;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    x_re_in  = 22'sd123;
    repeat (3) tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %0d expected 0", out_valid); end
    n_checks++;
    if (y_re_out !== 22'sd0 || y_im_out !== 22'sd0) begin
      n_errors++; $display("FAIL reset_y: got %0d,%0d expected 0,0", y_re_out, y_im_out);
    end
    n_checks++;
    if (out_idx !== 5'd0) begin n_errors++; $display("FAIL reset_idx: got %0d expected 0", out_idx); end
    n_checks++;
    if (fb_en !== 1'b0) begin n_errors++; $display("FAIL reset_fb_en: got %0d expected 0", fb_en); end
    in_valid = 1'b0;
    x_re_in  = '0;
    rst_n    = 1'b1;
  endtask

  task automatic test_impulse();
    do_reset();
    fill_const(0, 0);
    fr_re[0] = 1000;
    push_frame();
    pulses = 0;
    drive(0, 31);
    wait_empty(100);
    repeat (20) tick();
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL impulse_timeout: %0d outputs missing, expected 0", exp_q.size()); end
    n_checks++;
    if (pulses != 32) begin n_errors++; $display("FAIL impulse_pulses: got %0d expected 32", pulses); end
    n_checks++;
    if (fb_en !== 1'b0) begin n_errors++; $display("FAIL impulse_idle_fb_en: got %0d expected 0", fb_en); end
  endtask

  task automatic test_dc();
    do_reset();
    fill_const(100, 100);
    push_frame();
    drive(0, 31);
    wait_empty(100);
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL dc_timeout: %0d outputs missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_twiddle();
    do_reset();
    fill_const(0, 0);
    fr_re[8] = 512;
    push_frame();
    drive(0, 31);
    wait_empty(100);
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL twiddle_timeout: %0d outputs missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_drain_resume();
    do_reset();
    fill_rand();
    push_frame();
    drive(0, 31);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b0;
      #2;
      if (i == 0) begin
        n_checks++;
        if (fb_en !== 1'b1) begin n_errors++; $display("FAIL drain_fb_en: got %0d expected 1", fb_en); end
      end
      tick();
    end
    fill_rand();
    for (int i = 0; i < 5; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
    push_frame();
    drive(5, 31);
    wait_empty(100);
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL drain_timeout: %0d outputs missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    logic signed [21:0] y_save_re, y_save_im;
    do_reset();
    fill_rand();
    push_frame();
    drive(0, 31);
    fill_rand();
    push_frame();
    drive(0, 9);
    y_save_re = y_re_out;
    y_save_im = y_im_out;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0;
      #2;
      n_checks++;
      if (fb_en !== 1'b0) begin n_errors++; $display("FAIL stall_fb_en: cycle %0d got %0d expected 0", i, fb_en); end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL stall_out_valid: got %0d expected 0", out_valid); end
    n_checks++;
    if (y_re_out !== y_save_re || y_im_out !== y_save_im) begin
      n_errors++; $display("FAIL stall_y_hold: got %0d,%0d expected %0d,%0d", y_re_out, y_im_out, y_save_re, y_save_im);
    end
    drive(10, 31);
    wait_empty(100);
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL stall_timeout: %0d outputs missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int gaps;
    do_reset();
    gaps = 0;
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      push_frame();
      for (int i = 0; i < 32; i++) begin
        in_valid = 1'b1;
        x_re_in  = 22'(fr_re[i]);
        x_im_in  = 22'(fr_im[i]);
        tick();
        if (f * 32 + i >= 16 && out_valid !== 1'b1) gaps++;
      end
    end
    in_valid = 1'b0;
    x_re_in  = '0;
    x_im_in  = '0;
    n_checks++;
    if (gaps != 0) begin n_errors++; $display("FAIL b2b_gaps: got %0d idle output cycles expected 0", gaps); end
    wait_empty(100);
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL b2b_timeout: %0d outputs missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    fill_rand();
    push_frame();
    drive(0, 19);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || y_re_out !== 22'sd0 || y_im_out !== 22'sd0 || out_idx !== 5'd0) begin
      n_errors++;
      $display("FAIL midreset_outputs: got v=%0d y=%0d,%0d idx=%0d expected all 0",
               out_valid, y_re_out, y_im_out, out_idx);
    end
    n_checks++;
    if (fb_en !== 1'b0) begin n_errors++; $display("FAIL midreset_fb_en: got %0d expected 0", fb_en); end
    exp_q.delete();
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    fill_const(0, 0);
    fr_re[0] = 1000;
    fr_im[3] = -77;
    push_frame();
    drive(0, 31);
    wait_empty(100);
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL midreset_timeout: %0d outputs missing, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_twiddle();
    test_drain_resume();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
